aska_charge_monitor: RTL and testbench

//  Safety stage directly downstream of the ASKA neuromuscular pulse generator, in front of the H-bridge/DAC pads.

---
 rtl/aska_charge_monitor_pkg.sv | 26 ++
 rtl/aska_sat_cnt.sv | 33 +++
 rtl/aska_charge_monitor.sv | 248 ++++++++++++++++++++++++
 tb/tb_aska_charge_monitor.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aska_charge_monitor_pkg.sv
// Shared definitions for the ASKA charge-balance monitor.
//   - FSM state encoding (3 bit)
//   - default widths: electrode lines (ELEC_NUM + 1), accumulator width, DAC and counter widths
// Imported by aska_charge_monitor.
package aska_charge_monitor_pkg;

  localparam int unsigned ElecNum   = 7;
  localparam int unsigned ElecWDef  = ElecNum + 1;
  localparam int unsigned AccWDef   = 12;
  localparam int unsigned TolDef    = 0;
  localparam int unsigned DacW      = 6;
  localparam int unsigned PulseCntW = 16;
  localparam int unsigned ErrCntW   = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StPh1   = 3'd2,
    StGap   = 3'd3,
    StPh2   = 3'd4,
    StTail  = 3'd5,
    StErr   = 3'd6,
    StCheck = 3'd7
  } state_e;

endpackage

// File: rtl/aska_sat_cnt.sv
// Saturating up-counter used for the pulse and error statistics.
// Ports:
//   clk   in  clock
//   reset in  synchronous reset, active-high (clears q)
//   inc   in  increment request; ignored once q is all ones
//   q     out counter value
module aska_sat_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q;
    if (inc && (q != {WIDTH{1'b1}})) begin
      q_d = q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/aska_charge_monitor.sv
// ASKA charge-balance monitor. Sits between the pulse generator and the H-bridge/DAC pads,
// integrates DAC x cycles per phase of each biphasic pulse and flags imbalanced or malformed
// pulses. Keeps pulse/error statistics.
//
// Build option: define ASKA_CHGMON_LATCH_EN to make 'fault' sticky (set by a failing verdict,
// cleared by reset or clr_fault, set wins) and to force the pad outputs to zero while it is set.
// Without it, fault mirrors chk_imbalance, pad outputs are a passthrough, clr_fault is ignored.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   up_switches, down_switches      switch requests from the pulse generator
//   DAC                             amplitude code from the pulse generator
//   pulse_active                    high for the whole duration of one pulse
//   clr_fault                       clears the sticky fault (latch build only)
//   up_switches_o, down_switches_o  gated switch drive to the pads
//   DAC_o                           gated DAC code to the pads
//   chk_done                        one-cycle strobe: verdict ready
//   chk_imbalance, chk_charge       verdict and signed net charge of the last pulse (held)
//   pulse_cnt, err_cnt              saturating checked-pulse / failed-pulse counters
//   fault                           fault status
module aska_charge_monitor
  import aska_charge_monitor_pkg::*;
#(
  parameter int unsigned ELEC_W = ElecWDef,
  parameter int unsigned ACC_W  = AccWDef,
  parameter int unsigned TOL    = TolDef
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ELEC_W-1:0]    up_switches,
  input  logic [ELEC_W-1:0]    down_switches,
  input  logic [DacW-1:0]      DAC,
  input  logic                 pulse_active,
  input  logic                 clr_fault,
  output logic [ELEC_W-1:0]    up_switches_o,
  output logic [ELEC_W-1:0]    down_switches_o,
  output logic [DacW-1:0]      DAC_o,
  output logic                 chk_done,
  output logic                 chk_imbalance,
  output logic [ACC_W-1:0]     chk_charge,
  output logic [PulseCntW-1:0] pulse_cnt,
  output logic [ErrCntW-1:0]   err_cnt,
  output logic                 fault
);

  localparam int unsigned PatW = 2 * ELEC_W;
  // One guard bit: enough for acc +/- DAC before saturation and for |most negative acc|.
  localparam int unsigned ExtW = ACC_W + 1;
  localparam logic [ExtW-1:0] TolExt = ExtW'(TOL);

  state_e state_q, state_d;

  logic [PatW-1:0]  pat, pat1_q, pat1_d, mirror;
  logic [ACC_W-1:0] acc_q, acc_d, acc_add, acc_sub;
  logic [ExtW-1:0]  acc_ext, dac_ext, acc_mag;
  logic             pa_q, rise, fall;
  logic             err_q, err_d;
  logic             over_tol, imb_now, check_load;
  logic             chk_imbalance_q;
  logic [ACC_W-1:0] chk_charge_q;
  logic             gate;

  // Clamp a guard-extended sum back into ACC_W bits.
  function automatic logic [ACC_W-1:0] sat_res(input logic [ExtW-1:0] s);
    if (s[ExtW-1] != s[ExtW-2]) begin
      return s[ExtW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return s[ACC_W-1:0];
  endfunction

  assign pat    = {up_switches, down_switches};
  assign mirror = {pat1_q[ELEC_W-1:0], pat1_q[PatW-1:ELEC_W]};
  assign rise   = pulse_active & ~pa_q;
  assign fall   = ~pulse_active & pa_q;

  assign acc_ext = {acc_q[ACC_W-1], acc_q};
  assign dac_ext = ExtW'(DAC);
  assign acc_add = sat_res(acc_ext + dac_ext);
  assign acc_sub = sat_res(acc_ext - dac_ext);
  assign acc_mag = acc_q[ACC_W-1] ? (ExtW'(0) - acc_ext) : acc_ext;
  assign over_tol = (acc_mag > TolExt);

  // A pulse that ends before reaching the second phase is monophasic.
  assign imb_now = err_q | (state_q == StPh1) | (state_q == StGap) | over_tol;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pat1_d     = pat1_q;
    err_d      = err_q;
    check_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = StArmed;
          // The rising cycle already behaves like ARMED.
          if (pat != '0) begin
            pat1_d  = pat;
            acc_d   = ACC_W'(DAC);
            state_d = StPh1;
          end
        end
      end
      StArmed: begin
        if (fall) begin
          state_d = StIdle;
        end else if (pat != '0) begin
          pat1_d  = pat;
          acc_d   = acc_add;
          state_d = StPh1;
        end
      end
      StPh1: begin
        if (fall) begin
          state_d    = StCheck;
          check_load = 1'b1;
        end else if (pat == pat1_q) begin
          acc_d = acc_add;
        end else if (pat == '0) begin
          state_d = StGap;
        end else if (pat == mirror) begin
          acc_d   = acc_sub;
          state_d = StPh2;
        end else begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StGap: begin
        if (fall) begin
          state_d    = StCheck;
          check_load = 1'b1;
        end else if (pat == mirror) begin
          acc_d   = acc_sub;
          state_d = StPh2;
        end else if (pat != '0) begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StPh2: begin
        if (fall) begin
          state_d    = StCheck;
          check_load = 1'b1;
        end else if (pat == mirror) begin
          acc_d = acc_sub;
        end else if (pat == '0) begin
          state_d = StTail;
        end else begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StTail: begin
        if (fall) begin
          state_d    = StCheck;
          check_load = 1'b1;
        end else if (pat != '0) begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StErr: begin
        if (fall) begin
          state_d    = StCheck;
          check_load = 1'b1;
        end
      end
      StCheck: begin
        // A rise landing here is dropped; the generator guarantees an OFF cycle.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      pa_q            <= 1'b0;
      acc_q           <= '0;
      pat1_q          <= '0;
      err_q           <= 1'b0;
      chk_imbalance_q <= 1'b0;
      chk_charge_q    <= '0;
    end else begin
      state_q <= state_d;
      pa_q    <= pulse_active;
      acc_q   <= acc_d;
      pat1_q  <= pat1_d;
      err_q   <= err_d;
      if (check_load) begin
        chk_imbalance_q <= imb_now;
        chk_charge_q    <= acc_q;
      end
    end
  end

  assign chk_done      = (state_q == StCheck);
  assign chk_imbalance = chk_imbalance_q;
  assign chk_charge    = chk_charge_q;

  aska_sat_cnt #(
    .WIDTH(PulseCntW)
  ) u_pulse_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (chk_done),
    .q    (pulse_cnt)
  );

  aska_sat_cnt #(
    .WIDTH(ErrCntW)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (chk_done & chk_imbalance_q),
    .q    (err_cnt)
  );

`ifdef ASKA_CHGMON_LATCH_EN
  logic fault_q;

  // Set has priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (chk_done & chk_imbalance_q) | (fault_q & ~clr_fault);
    end
  end

  assign fault = fault_q;
  assign gate  = fault_q;
`else
  logic unused_clr_fault;
  assign unused_clr_fault = clr_fault;
  assign fault = chk_imbalance_q;
  assign gate  = 1'b0;
`endif

  assign up_switches_o   = gate ? '0 : up_switches;
  assign down_switches_o = gate ? '0 : down_switches;
  assign DAC_o           = gate ? '0 : DAC;

endmodule

// File: tb/tb_aska_charge_monitor.sv
// Self-checking bench for aska_charge_monitor: directed pulses with literal expectations plus
// randomized pulses, all compared every cycle against a sequence-level reference model.
module tb_aska_charge_monitor;

  localparam int ELEC_W = 8;
  localparam int ACC_W  = 12;
  localparam int TOL    = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  up_switches, down_switches;
  logic [5:0]  DAC;
  logic        pulse_active, clr_fault;
  logic [7:0]  up_switches_o, down_switches_o;
  logic [5:0]  DAC_o;
  logic        chk_done, chk_imbalance, fault;
  logic [11:0] chk_charge;
  logic [15:0] pulse_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  aska_charge_monitor #(
    .ELEC_W(ELEC_W),
    .ACC_W (ACC_W),
    .TOL   (TOL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .up_switches    (up_switches),
    .down_switches  (down_switches),
    .DAC            (DAC),
    .pulse_active   (pulse_active),
    .clr_fault      (clr_fault),
    .up_switches_o  (up_switches_o),
    .down_switches_o(down_switches_o),
    .DAC_o          (DAC_o),
    .chk_done       (chk_done),
    .chk_imbalance  (chk_imbalance),
    .chk_charge     (chk_charge),
    .pulse_cnt      (pulse_cnt),
    .err_cnt        (err_cnt),
    .fault          (fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (whole-pulse view) ----------------
  bit          m_valid = 0;
  bit          m_pa, m_in, m_done, m_imb, m_fault;
  int          m_charge, m_pcnt, m_ecnt;
  logic [15:0] q_pat[$];
  int          q_dac[$];

  function automatic int sat_acc(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic logic [15:0] mir(input logic [15:0] p);
    return {p[7:0], p[15:8]};
  endfunction

  // Parse a recorded pulse: lead zeros, phase-1 run, gap, mirrored run, tail; leftovers = error.
  task automatic evaluate(output bit have, output bit imb, output int charge);
    int          n = q_pat.size();
    int          i = 0;
    int          acc = 0;
    bit          ph2 = 0;
    logic [15:0] p1, mr;
    have = 0;
    imb = 0;
    charge = 0;
    while (i < n && q_pat[i] == 16'h0) i++;
    if (i == n) return;
    have = 1;
    p1 = q_pat[i];
    mr = mir(p1);
    while (i < n && q_pat[i] == p1) begin acc = sat_acc(acc + q_dac[i]); i++; end
    while (i < n && q_pat[i] == 16'h0) i++;
    while (i < n && q_pat[i] == mr) begin acc = sat_acc(acc - q_dac[i]); ph2 = 1; i++; end
    if (ph2) while (i < n && q_pat[i] == 16'h0) i++;
    imb = (i < n) || !ph2 || (acc > TOL) || (-acc > TOL);
    charge = acc;
  endtask

  task automatic model_step();
    bit have, imb, nd;
    int ch;
    m_valid = 1;
    nd = 0;
    if (reset) begin
      m_pa = 0; m_in = 0; m_done = 0; m_imb = 0; m_fault = 0;
      m_charge = 0; m_pcnt = 0; m_ecnt = 0;
      q_pat.delete();
      q_dac.delete();
      return;
    end
    if (m_done) begin
      if (m_pcnt < 65535) m_pcnt++;
      if (m_imb && m_ecnt < 255) m_ecnt++;
    end
`ifdef ASKA_CHGMON_LATCH_EN
    m_fault = (m_done && m_imb) || (m_fault && !clr_fault);
`endif
    if (m_in) begin
      if (!pulse_active) begin
        evaluate(have, imb, ch);
        if (have) begin nd = 1; m_imb = imb; m_charge = ch; end
        m_in = 0;
      end else begin
        q_pat.push_back({up_switches, down_switches});
        q_dac.push_back(int'(DAC));
      end
    end else if (pulse_active && !m_pa && !m_done) begin
      m_in = 1;
      q_pat.delete();
      q_dac.delete();
      q_pat.push_back({up_switches, down_switches});
      q_dac.push_back(int'(DAC));
    end
    m_done = nd;
    m_pa = pulse_active;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [11:0] ec;
    bit          g;
    if (m_valid) begin
      ec = m_charge[11:0];
`ifdef ASKA_CHGMON_LATCH_EN
      g = m_fault;
      check("fault", fault, m_fault);
`else
      g = 0;
      check("fault", fault, m_imb);
`endif
      check("chk_done", chk_done, m_done);
      check("chk_imbalance", chk_imbalance, m_imb);
      check("chk_charge", chk_charge, ec);
      check("pulse_cnt", pulse_cnt, m_pcnt);
      check("err_cnt", err_cnt, m_ecnt);
      check("up_switches_o", up_switches_o, g ? 8'h0 : up_switches);
      check("down_switches_o", down_switches_o, g ? 8'h0 : down_switches);
      check("DAC_o", DAC_o, g ? 6'h0 : DAC);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit pa, input logic [15:0] p, input logic [5:0] d,
                     input bit clr = 0, input bit rst = 0);
    pulse_active  = pa;
    up_switches   = p[15:8];
    down_switches = p[7:0];
    DAC           = d;
    clr_fault     = clr;
    reset         = rst;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic body(input logic [15:0] p1, input int n1, input int a1, input int gap,
                      input int n2, input int a2);
    for (int i = 0; i < n1; i++) cyc(1, p1, 6'(a1));
    for (int i = 0; i < gap; i++) cyc(1, 16'h0, 6'(0));
    for (int i = 0; i < n2; i++) cyc(1, mir(p1), 6'(a2));
  endtask

  task automatic rand_pulse();
    int          kind, n1, n2, gap, tail, a1, a2, pos, mid;
    logic [15:0] p1, rp[$];
    int          rd[$];
    kind = $urandom_range(0, 9);
    p1 = 16'($urandom);
    if (p1 == 16'h0) p1 = 16'h0001;
    n1 = $urandom_range(1, 4);
    gap = $urandom_range(0, 2);
    tail = $urandom_range(0, 2);
    a1 = $urandom_range(0, 63);
    n2 = n1;
    a2 = a1;
    if (kind == 4) begin n2 = $urandom_range(0, 4); a2 = $urandom_range(0, 63); end
    if (kind == 8) begin n1 = $urandom_range(30, 40); a1 = 63; n2 = $urandom_range(0, 3); end
    for (int i = 0; i < $urandom_range(0, 1); i++) begin rp.push_back(16'h0); rd.push_back(a1); end
    if (kind != 6) begin
      for (int i = 0; i < n1; i++) begin
        rp.push_back(p1);
        rd.push_back(kind == 9 ? $urandom_range(0, 63) : a1);
      end
      for (int i = 0; i < gap; i++) begin rp.push_back(16'h0); rd.push_back($urandom_range(0, 63)); end
      for (int i = 0; i < n2; i++) begin
        rp.push_back(mir(p1));
        rd.push_back(kind == 9 ? $urandom_range(0, 63) : a2);
      end
      for (int i = 0; i < tail; i++) begin rp.push_back(16'h0); rd.push_back(0); end
    end else begin
      for (int i = 0; i < 3; i++) begin rp.push_back(16'h0); rd.push_back($urandom_range(0, 63)); end
    end
    if (kind == 5) begin
      pos = $urandom_range(0, rp.size());
      rp.insert(pos, 16'($urandom));
      rd.insert(pos, $urandom_range(0, 63));
    end
    mid = (kind == 7) ? $urandom_range(0, rp.size() - 1) : -1;
    for (int i = 0; i < rp.size(); i++) begin
      cyc(1, rp[i], 6'(rd[i]), $urandom_range(0, 7) == 0, i == mid);
    end
    cyc(0, 16'($urandom), 6'($urandom), $urandom_range(0, 7) == 0);
    for (int i = 0; i < $urandom_range(1, 3); i++) begin
      cyc(0, 16'($urandom), 6'($urandom), $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    cyc(0, 16'h0, 6'd0, 0, 1);
    cyc(0, 16'h0, 6'd0, 0, 1);
    check("reset chk_done", chk_done, 0);
    check("reset pulse_cnt", pulse_cnt, 0);
    check("reset err_cnt", err_cnt, 0);
    check("reset fault", fault, 0);
    check("reset chk_charge", chk_charge, 0);
    cyc(0, 16'h0, 6'd0);

    // Balanced pulse
    body(16'h0102, 3, 20, 1, 3, 20);
    cyc(0, 16'h0, 6'd0);
    check("t1 chk_done", chk_done, 1);
    check("t1 charge", chk_charge, 0);
    check("t1 imbalance", chk_imbalance, 0);
    cyc(0, 16'h0, 6'd0);
    check("t1 pulse_cnt", pulse_cnt, 1);

    // Amplitude mismatch
    body(16'h0102, 3, 20, 1, 3, 18);
    cyc(0, 16'h0, 6'd0);
    check("t2 charge", chk_charge, 6);
    check("t2 imbalance", chk_imbalance, 1);
    cyc(0, 16'hAA55, 6'd33);
    check("t2 err_cnt", err_cnt, 1);
    check("t2 fault", fault, 1);
`ifdef ASKA_CHGMON_LATCH_EN
    check("t2 gated up", up_switches_o, 8'h00);
    check("t2 gated dac", DAC_o, 6'h00);
    cyc(0, 16'hAA55, 6'd33, 1);
    check("t5 fault cleared", fault, 0);
    check("t5 passthrough", up_switches_o, 8'hAA);
    body(16'h0102, 2, 10, 0, 0, 0);
    cyc(0, 16'h0, 6'd0);
    cyc(0, 16'hAA55, 6'd33, 1);
    check("t5 set wins", fault, 1);
    check("t5 gated down", down_switches_o, 8'h00);
    cyc(0, 16'h0, 6'd0, 1);
`else
    check("t2 passthrough", up_switches_o, 8'hAA);
    cyc(0, 16'hAA55, 6'd33, 1);
    check("t5 clr ignored", fault, 1);
`endif

    // Monophasic, then illegal pattern after the gap
    body(16'h0304, 2, 5, 0, 0, 0);
    cyc(0, 16'h0, 6'd0);
    check("t3 mono imbalance", chk_imbalance, 1);
    check("t3 mono charge", chk_charge, 10);
    cyc(0, 16'h0, 6'd0);
    cyc(1, 16'h0304, 6'd7);
    cyc(1, 16'h0000, 6'd7);
    cyc(1, 16'h0304, 6'd7);
    cyc(1, 16'h0403, 6'd7);
    cyc(0, 16'h0, 6'd0);
    check("t3 err imbalance", chk_imbalance, 1);
    check("t3 err charge", chk_charge, 7);
    cyc(0, 16'h0, 6'd0);

    // Empty pulse
    for (int i = 0; i < 3; i++) cyc(1, 16'h0, 6'd12);
    cyc(0, 16'h0, 6'd0);
    check("t4 no verdict", chk_done, 0);
    cyc(0, 16'h0, 6'd0);
`ifdef ASKA_CHGMON_LATCH_EN
    check("t4 pulse_cnt", pulse_cnt, 5);
`else
    check("t4 pulse_cnt", pulse_cnt, 4);
`endif

    // Reset in PH2
    cyc(1, 16'h0102, 6'd20);
    cyc(1, 16'h0102, 6'd20);
    cyc(1, 16'h0201, 6'd20);
    cyc(0, 16'h0, 6'd0, 0, 1);
    check("t6 chk_done", chk_done, 0);
    check("t6 pulse_cnt", pulse_cnt, 0);
    check("t6 err_cnt", err_cnt, 0);
    check("t6 charge", chk_charge, 0);
    cyc(0, 16'h0, 6'd0);
    body(16'h0810, 4, 33, 2, 4, 33);
    cyc(0, 16'h0, 6'd0);
    check("t6 done", chk_done, 1);
    check("t6 balanced", chk_imbalance, 0);
    cyc(0, 16'h0, 6'd0);
    check("t6 pulse_cnt after", pulse_cnt, 1);

    // Accumulator saturation both ways
    body(16'h0001, 40, 63, 0, 1, 0);
    cyc(0, 16'h0, 6'd0);
    check("sat pos", chk_charge, 12'h7FF);
    cyc(0, 16'h0, 6'd0);
    body(16'h0100, 1, 0, 0, 40, 63);
    cyc(0, 16'h0, 6'd0);
    check("sat neg", chk_charge, 12'h800);
    cyc(0, 16'h0, 6'd0);

    // err_cnt saturation
    for (int i = 0; i < 260; i++) begin
      cyc(1, 16'h0100, 6'd1);
      cyc(0, 16'h0, 6'd0, 1);
      cyc(0, 16'h0, 6'd0, 1);
    end
    check("err_cnt sat", err_cnt, 255);
    check("pulse_cnt 263", pulse_cnt, 263);

    // Randomized pulses
    for (int i = 0; i < 300; i++) rand_pulse();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
